// File: rtl/fifo_word_packer_lib.sv
// fifo_word_packer_lib
// Pops DATA_SIZE-bit words from an upstream one-in/one-out FIFO through its
// valid/pick-ready handshake. It packs PACK_NUM consecutive words into one
// wide beat and presents that beat on a registered valid/ready output.
// A flush closes a partially filled beat. out_mask marks which slots of the
// beat are populated, and unpopulated slots are always zero.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous, active-high reset
//   in_vld    FIFO has a word
//   in_data   FIFO head word
//   pick_rdy  pop request to the FIFO (word consumed when in_vld & pick_rdy)
//   flush     close the current partial beat
//   out_vld   wide beat valid
//   out_data  packed beat; word k at [k*DATA_SIZE +: DATA_SIZE]
//   out_mask  bit k set = slot k populated
//   out_rdy   downstream accepts the beat when out_vld & out_rdy
//   busy      a beat is partially filled or is being presented
module fifo_word_packer_lib #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned PACK_NUM       = 4,
  parameter int unsigned PACK_NUM_WIDTH = $clog2(PACK_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  input  logic [DATA_SIZE-1:0]          in_data,
  output logic                          pick_rdy,
  input  logic                          flush,
  output logic                          out_vld,
  output logic [PACK_NUM*DATA_SIZE-1:0] out_data,
  output logic [PACK_NUM-1:0]           out_mask,
  input  logic                          out_rdy,
  output logic                          busy
);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                        state_q, state_d;
  logic [PACK_NUM_WIDTH-1:0]     cnt_q, cnt_d;
  logic [PACK_NUM*DATA_SIZE-1:0] data_q, data_d;
  logic [PACK_NUM-1:0]           mask_q, mask_d;

  logic acc;
  logic fire;

  assign acc  = in_vld & pick_rdy;
  assign fire = out_vld & out_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          for (int unsigned k = 0; k < PACK_NUM; k++) begin
            if (cnt_q == PACK_NUM_WIDTH'(k)) begin
              data_d[k*DATA_SIZE +: DATA_SIZE] = in_data;
              mask_d[k]                        = 1'b1;
            end
          end
          if (cnt_q == PACK_NUM_WIDTH'(PACK_NUM - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PACK_NUM_WIDTH'(1);
          end
        end
        // A word accepted in the same cycle as flush is already in data_d.
        if (flush && ((cnt_q != '0) || acc)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // pick_rdy in HOLD requires out_rdy, so acc here always implies fire.
        if (fire) begin
          state_d = FILL;
          data_d  = '0;
          mask_d  = '0;
          cnt_d   = '0;
          if (acc) begin
            data_d[DATA_SIZE-1:0] = in_data;
            mask_d[0]             = 1'b1;
            cnt_d                 = PACK_NUM_WIDTH'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    pick_rdy = ~rst & ((state_q == FILL) | ((state_q == HOLD) & out_rdy));
    out_vld  = (state_q == HOLD);
    out_data = data_q;
    out_mask = mask_q;
    busy     = (cnt_q != '0) | (state_q == HOLD);
  end

endmodule

// File: tb/tb_fifo_word_packer_lib.sv
module tb_fifo_word_packer_lib;

  localparam int unsigned DW = 32;
  localparam int unsigned PN = 4;

  logic           clk;
  logic           rst;
  logic           in_vld;
  logic [DW-1:0]  in_data;
  logic           pick_rdy;
  logic           flush;
  logic           out_vld;
  logic [PN*DW-1:0] out_data;
  logic [PN-1:0]  out_mask;
  logic           out_rdy;
  logic           busy;

  typedef struct {
    logic [PN*DW-1:0] data;
    logic [PN-1:0]    mask;
  } beat_t;

  beat_t expq[$];
  int checks;
  int failures;

  fifo_word_packer_lib #(
    .DATA_SIZE(DW),
    .PACK_NUM(PN),
    .PACK_NUM_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_data(in_data),
    .pick_rdy(pick_rdy),
    .flush(flush),
    .out_vld(out_vld),
    .out_data(out_data),
    .out_mask(out_mask),
    .out_rdy(out_rdy),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PN*DW-1:0] act, input logic [PN*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [PN*DW-1:0] d, input logic [PN-1:0] m);
    beat_t b;
    b.data = d;
    b.mask = m;
    expq.push_back(b);
  endtask

  // Apply inputs, then advance to just after the next rising edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
    in_vld  = v;
    in_data = d;
    flush   = f;
    out_rdy = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a beat is consumed at the next edge whenever
  // out_vld & out_rdy hold at the falling edge.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%h/%b required=none", out_data, out_mask);
      end else begin
        beat_t e;
        e = expq.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_mask", {{(PN*DW-PN){1'b0}}, out_mask}, {{(PN*DW-PN){1'b0}}, e.mask});
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_vld   = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    out_rdy  = 1'b1;

    // Reset state
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    chk("rst_out_vld", {127'b0, out_vld}, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask", {124'b0, out_mask}, '0);
    chk("rst_busy", {127'b0, busy}, '0);
    chk("rst_pick_rdy", {127'b0, pick_rdy}, '0);
    rst = 1'b0;

    // Streaming: two back-to-back beats, pick_rdy never drops
    push({32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111);
    push({32'h88, 32'h77, 32'h66, 32'h55}, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(32'h11 * (i + 1)), 1'b0, 1'b1);
      chk("stream_pick_rdy", {127'b0, pick_rdy}, 128'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("stream_done_vld", {127'b0, out_vld}, '0);

    // Flush partial with no word in the flush cycle
    push({32'h0, 32'h0, 32'hA1, 32'hA0}, 4'b0011);
    drive(1'b1, 32'hA0, 1'b0, 1'b1);
    drive(1'b1, 32'hA1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("flush_vld", {127'b0, out_vld}, 128'd1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Flush with a word accepted in the same cycle
    push({32'h0, 32'hA2, 32'hA1, 32'hA0}, 4'b0111);
    drive(1'b1, 32'hA0, 1'b0, 1'b1);
    drive(1'b1, 32'hA1, 1'b0, 1'b1);
    drive(1'b1, 32'hA2, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Idle flush emits nothing
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("idle_flush_vld", {127'b0, out_vld}, '0);
    chk("idle_flush_busy", {127'b0, busy}, '0);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: hold a full beat for 5 cycles
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
      chk("stall_pick_rdy", {127'b0, pick_rdy}, '0);
      chk("stall_vld", {127'b0, out_vld}, 128'd1);
      chk("stall_data", out_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
      chk("stall_mask", {124'b0, out_mask}, 128'hF);
    end
    push({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'b1111);
    drive(1'b1, 32'hB0, 1'b0, 1'b1);
    in_vld = 1'b0;
    #1;
    chk("refill_vld", {127'b0, out_vld}, '0);
    chk("refill_data", out_data, {32'h0, 32'h0, 32'h0, 32'hB0});
    chk("refill_mask", {124'b0, out_mask}, 128'h1);
    chk("refill_busy", {127'b0, busy}, 128'd1);
    push({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1111);
    for (int i = 1; i < 4; i++) drive(1'b1, DW'(32'hB0 + i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Reset after 3 words accepted
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'hD0 + i), 1'b0, 1'b1);
    rst     = 1'b1;
    in_vld  = 1'b1;
    in_data = 32'hEE;
    #1;
    chk("rst_mid_pick_rdy", {127'b0, pick_rdy}, '0);
    @(posedge clk);
    #1;
    chk("rst_mid_vld", {127'b0, out_vld}, '0);
    chk("rst_mid_data", out_data, '0);
    chk("rst_mid_mask", {124'b0, out_mask}, '0);
    chk("rst_mid_busy", {127'b0, busy}, '0);
    rst = 1'b0;
    push({32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'b1111);
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'hE0 + i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Reset during HOLD discards the held beat
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'hF0 + i), 1'b0, 1'b0);
    chk("hold_vld", {127'b0, out_vld}, 128'd1);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("rst_hold_pick_rdy", {127'b0, pick_rdy}, '0);
    chk("rst_hold_vld", {127'b0, out_vld}, '0);
    chk("rst_hold_data", out_data, '0);
    chk("rst_hold_mask", {124'b0, out_mask}, '0);
    chk("rst_hold_busy", {127'b0, busy}, '0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    push({32'h0, 32'h0, 32'h0, 32'h77}, 4'b0001);
    drive(1'b1, 32'h77, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);

    chk("scoreboard_empty", 128'(expq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
